// File: rtl/window_pkg.sv
// Shared definitions for the 3x3 window generator: FSM encoding and tap packing.
package window_pkg;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_RUN_ENC   = 2'd1;
  localparam logic [1:0] ST_FLUSH_ENC = 2'd2;
  localparam logic [1:0] ST_DONE_ENC  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_RUN   = ST_RUN_ENC,
    ST_FLUSH = ST_FLUSH_ENC,
    ST_DONE  = ST_DONE_ENC
  } state_t;

  // Tap k (1..9) occupies bits [k*data_w-1 -: data_w] of the packed window.
  function automatic int tap_lsb(input int k, input int data_w);
    return (k - 1) * data_w;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of storage; asynchronous read returns the old word when the
// same address is written on the coming edge.
module line_buffer #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus per-row tap
// history produce every interior window of a raster-order frame.
//
// state    | meaning
// ST_IDLE  | waiting for start after reset
// ST_RUN   | accepting pixels, emitting windows
// ST_FLUSH | last pixel taken, final window on the outputs
// ST_DONE  | frame finished, complete high until next start
module window_gen_3x3
  import window_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     pix_in,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic [9*DATA_W-1:0]   win_out,
  output logic                  win_valid,
  output logic [CNT_W-1:0]      win_x,
  output logic [CNT_W-1:0]      win_y,
  output logic                  complete
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(IMG_H - 1);

  state_t            state;
  logic [CNT_W-1:0]  x;
  logic [CNT_W-1:0]  y;
  logic              xfer;
  logic              emit;
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] mid_rd;
  logic [DATA_W-1:0] top_rd;

  // Index 0 is column x-2, index 1 is column x-1 relative to the incoming pixel.
  logic [DATA_W-1:0] top_h [2];
  logic [DATA_W-1:0] mid_h [2];
  logic [DATA_W-1:0] bot_h [2];
  logic [DATA_W-1:0] taps  [9];
  logic [9*DATA_W-1:0] win_next;

  assign xfer = pix_valid & pix_ready;
  assign emit = xfer && (x >= CNT_W'(2)) && (y >= CNT_W'(2));
  assign addr = x[AW-1:0];

  line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W), .AW(AW)) u_buf0 (
    .clk   (clk),
    .we    (xfer),
    .addr  (addr),
    .wdata (pix_in),
    .rdata (mid_rd)
  );

  line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W), .AW(AW)) u_buf1 (
    .clk   (clk),
    .we    (xfer),
    .addr  (addr),
    .wdata (mid_rd),
    .rdata (top_rd)
  );

  always_comb begin
    taps[0] = top_h[0];
    taps[1] = top_h[1];
    taps[2] = top_rd;
    taps[3] = mid_h[0];
    taps[4] = mid_h[1];
    taps[5] = mid_rd;
    taps[6] = bot_h[0];
    taps[7] = bot_h[1];
    taps[8] = pix_in;
  end

  always_comb begin
    win_next = '0;
    for (int k = 1; k <= 9; k++) begin
      win_next[tap_lsb(k, DATA_W) +: DATA_W] = taps[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      x         <= '0;
      y         <= '0;
      pix_ready <= 1'b0;
      complete  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_RUN;
            x         <= '0;
            y         <= '0;
            pix_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          if (xfer) begin
            if (x == X_LAST) begin
              x <= '0;
              y <= y + CNT_W'(1);
              if (y == Y_LAST) begin
                state     <= ST_FLUSH;
                pix_ready <= 1'b0;
              end
            end else begin
              x <= x + CNT_W'(1);
            end
          end
        end
        ST_FLUSH: begin
          state    <= ST_DONE;
          complete <= 1'b1;
        end
        ST_DONE: begin
          if (start) begin
            state     <= ST_RUN;
            x         <= '0;
            y         <= '0;
            pix_ready <= 1'b1;
            complete  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_valid <= 1'b0;
      win_out   <= '0;
      win_x     <= '0;
      win_y     <= '0;
      for (int i = 0; i < 2; i++) begin
        top_h[i] <= '0;
        mid_h[i] <= '0;
        bot_h[i] <= '0;
      end
    end else begin
      win_valid <= emit;
      if (xfer) begin
        top_h[0] <= top_h[1];
        top_h[1] <= top_rd;
        mid_h[0] <= mid_h[1];
        mid_h[1] <= mid_rd;
        bot_h[0] <= bot_h[1];
        bot_h[1] <= pix_in;
      end
      if (emit) begin
        win_out <= win_next;
        win_x   <= x - CNT_W'(1);
        win_y   <= y - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3: ramp frames, stalls, restart, abort and a
// smaller 5x4 / 12-bit instance.
module tb_window_gen_3x3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        pix_ready;
  logic [71:0] win_out;
  logic        win_valid;
  logic [7:0]  win_x;
  logic [7:0]  win_y;
  logic        complete;

  logic         start_b;
  logic [11:0]  pix_in_b;
  logic         pix_valid_b;
  logic         pix_ready_b;
  logic [107:0] win_out_b;
  logic         win_valid_b;
  logic [7:0]   win_x_b;
  logic [7:0]   win_y_b;
  logic         complete_b;

  int total = 0;
  int bad   = 0;

  logic [71:0] wq [$];
  int          xq [$];
  int          yq [$];
  int          stall_viol = 0;
  logic        xfer_q = 1'b0;

  int           nb = 0;
  logic [107:0] first_b, last_b;
  int           fx_b, fy_b, lx_b, ly_b;

  always #5 clk = ~clk;

  window_gen_3x3 #(.DATA_W(8), .IMG_W(8), .IMG_H(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .pix_in(pix_in),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .win_out(win_out),
    .win_valid(win_valid), .win_x(win_x), .win_y(win_y), .complete(complete)
  );

  window_gen_3x3 #(.DATA_W(12), .IMG_W(5), .IMG_H(4), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .pix_in(pix_in_b),
    .pix_valid(pix_valid_b), .pix_ready(pix_ready_b), .win_out(win_out_b),
    .win_valid(win_valid_b), .win_x(win_x_b), .win_y(win_y_b), .complete(complete_b)
  );

  always @(posedge clk) xfer_q <= pix_valid && pix_ready;

  always @(negedge clk) begin
    if (win_valid === 1'b1) begin
      wq.push_back(win_out);
      xq.push_back(int'(win_x));
      yq.push_back(int'(win_y));
      if (!xfer_q) stall_viol++;
    end
    if (win_valid_b === 1'b1) begin
      if (nb == 0) begin
        first_b = win_out_b; fx_b = int'(win_x_b); fy_b = int'(win_y_b);
      end
      last_b = win_out_b; lx_b = int'(win_x_b); ly_b = int'(win_y_b);
      nb++;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] model_win(input int cx, input int cy, input int off);
    logic [71:0] w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(r*3+c)*8 +: 8] = 8'(((cy - 1 + r) * 8 + (cx - 1 + c) + off) & 255);
    return w;
  endfunction

  task automatic clear_q();
    wq.delete(); xq.delete(); yq.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns one ns after the edge that accepted the last requested pixel.
  task automatic feed(input int off, input bit stall, input int n_pix, input bit lat_chk);
    int  idx = 0;
    int  cyc = 0;
    bit  acc;
    while (idx < n_pix && cyc < 3000) begin
      pix_in    = 8'((idx + off) & 255);
      pix_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      acc       = pix_valid && pix_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (lat_chk && idx == 18) begin
          chk("lat_valid", win_valid, 1);
          chk("lat_x", win_x, 1);
          chk("lat_y", win_y, 1);
          chk("lat_taps", win_out, model_win(1, 1, off));
        end
        idx++;
      end
    end
    pix_valid = 1'b0;
    if (idx < n_pix) chk("feed_timeout", idx, n_pix);
  endtask

  task automatic check_seq(input string tag, input int off);
    int errs = 0;
    chk({tag, "_count"}, wq.size(), 36);
    for (int i = 0; i < wq.size() && i < 36; i++) begin
      if (xq[i] != 1 + i % 6 || yq[i] != 1 + i / 6 ||
          wq[i] !== model_win(1 + i % 6, 1 + i / 6, off)) errs++;
    end
    chk({tag, "_seq"}, errs, 0);
  endtask

  task automatic frame_tail(input string tag);
    chk({tag, "_last_valid"}, win_valid, 1);
    chk({tag, "_cmp_early"}, complete, 0);
    @(posedge clk); #1;
    chk({tag, "_complete"}, complete, 1);
    chk({tag, "_wv_done"}, win_valid, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pix_in = '0; pix_valid = 1'b1;
    start_b = 1'b0; pix_in_b = '0; pix_valid_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", pix_ready, 0);
    chk("rst_wvalid", win_valid, 0);
    chk("rst_complete", complete, 0);
    chk("rst_win_out", win_out, 0);
    chk("rst_win_xy", {win_x, win_y}, 0);
    chk("rst_ready_b", pix_ready_b, 0);
    reset = 1'b0; pix_valid = 1'b0; pix_valid_b = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", pix_ready, 0);

    // Back-to-back ramp frame
    clear_q();
    do_start();
    chk("run_ready", pix_ready, 1);
    feed(0, 1'b0, 64, 1'b1);
    chk("last_x", win_x, 6);
    chk("last_y", win_y, 6);
    frame_tail("ramp");
    check_seq("ramp", 0);
    chk("ramp_first", wq[0], {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0});
    chk("ramp_last", wq[35], {8'd63, 8'd62, 8'd61, 8'd55, 8'd54, 8'd53, 8'd47, 8'd46, 8'd45});
    chk("ramp_last_xy", {xq[35], yq[35]}, {32'd6, 32'd6});

    // Randomly stalled ramp frame
    clear_q();
    stall_viol = 0;
    do_start();
    feed(0, 1'b1, 64, 1'b0);
    frame_tail("stall");
    check_seq("stall", 0);
    chk("stall_no_win", stall_viol, 0);

    // Restart from DONE with offset ramp
    clear_q();
    chk("pre_restart_complete", complete, 1);
    do_start();
    chk("restart_complete_drop", complete, 0);
    feed(100, 1'b0, 64, 1'b0);
    frame_tail("off");
    check_seq("off", 100);
    chk("off_first", wq[0], {8'd118, 8'd117, 8'd116, 8'd110, 8'd109, 8'd108, 8'd102, 8'd101, 8'd100});

    // Abort part-way through a frame
    do_start();
    feed(0, 1'b0, 31, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_ready", pix_ready, 0);
    chk("abort_wvalid", win_valid, 0);
    chk("abort_win_out", win_out, 0);
    clear_q();
    pix_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    pix_valid = 1'b0;
    chk("abort_no_win", wq.size(), 0);
    chk("abort_complete", complete, 0);
    do_start();
    feed(0, 1'b0, 64, 1'b0);
    frame_tail("post_abort");
    check_seq("post_abort", 0);
    chk("post_abort_first", wq[0], {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0});

    // 5x4 frame with 12-bit pixels
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    begin
      int idx = 0;
      int cyc = 0;
      bit acc;
      while (idx < 20 && cyc < 200) begin
        pix_in_b    = 12'(idx);
        pix_valid_b = 1'b1;
        acc         = pix_valid_b && pix_ready_b;
        @(posedge clk); #1;
        cyc++;
        if (acc) idx++;
      end
      pix_valid_b = 1'b0;
      if (idx < 20) chk("b_feed_timeout", idx, 20);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("b_count", nb, 6);
    chk("b_complete", complete_b, 1);
    chk("b_first_xy", {fx_b, fy_b}, {32'd1, 32'd1});
    chk("b_first", first_b,
        {12'd12, 12'd11, 12'd10, 12'd7, 12'd6, 12'd5, 12'd2, 12'd1, 12'd0});
    chk("b_last_xy", {lx_b, ly_b}, {32'd3, 32'd2});
    chk("b_last", last_b,
        {12'd19, 12'd18, 12'd17, 12'd14, 12'd13, 12'd12, 12'd9, 12'd8, 12'd7});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
